// File: rtl/adder_pkg.sv
// Shared types for the chunked adder: operation modes, FSM states and a
// counter-width helper.
package adder_pkg;

   typedef enum logic [1:0] {
      MODE_ADD = 2'b00,
      MODE_SUB = 2'b01,
      MODE_ACC = 2'b10,
      MODE_CLR = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_e;

   // A single-slice configuration still needs a 1-bit counter.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/chunked_adder_if.sv
// Operand request and result handshake bundle for chunked_adder.
interface chunked_adder_if #(
   parameter int WIDTH = 16
);
   import adder_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   mode_e            mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             overflow;

   modport master (
      output in_valid, op_a, op_b, mode, out_ready,
      input  in_ready, out_valid, result, carry, overflow
   );

   modport slave (
      input  in_valid, op_a, op_b, mode, out_ready,
      output in_ready, out_valid, result, carry, overflow
   );

endinterface

// File: rtl/chunk_add.sv
// CHUNK-bit combinational slice adder; exposes the slice MSBs so the top
// level can form the signed-overflow flag on the final slice.
module chunk_add #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             a_msb,
   output logic             b_msb,
   output logic             sum_msb
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
   assign a_msb       = a[CHUNK-1];
   assign b_msb       = b[CHUNK-1];
   assign sum_msb     = sum[CHUNK-1];

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle WIDTH-bit adder/accumulator processing CHUNK bits per cycle.
// Optional feature macro: SATURATE_EN (clamp result on signed overflow).
module chunked_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input logic            clk,
   input logic            rst,
   chunked_adder_if.slave bus
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = cnt_width(N);

   if (WIDTH % CHUNK != 0) begin : g_bad_cfg
      $error("chunked_adder: WIDTH must be a multiple of CHUNK");
   end

   state_e           state_q, state_d;
   mode_e            mode_q, mode_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
   logic [WIDTH-1:0] acc_q, acc_d, result_q, result_d;
   logic             cin_q, cin_d, carry_q, carry_d, overflow_q, overflow_d;

   logic [CHUNK-1:0] slice_sum;
   logic             slice_cout, x_msb, y_msb, sum_msb, slice_ovf;
   logic [WIDTH-1:0] x_shift, y_shift, final_res;
   logic             last_slice, accept;

   chunk_add #(.CHUNK(CHUNK)) u_slice (
      .a       (x_q[CHUNK-1:0]),
      .b       (y_q[CHUNK-1:0]),
      .cin     (cin_q),
      .sum     (slice_sum),
      .cout    (slice_cout),
      .a_msb   (x_msb),
      .b_msb   (y_msb),
      .sum_msb (sum_msb)
   );

   // x doubles as the result shift register: sums enter at the top as operand bits leave.
   if (N > 1) begin : g_multi
      assign x_shift = {slice_sum, x_q[WIDTH-1:CHUNK]};
      assign y_shift = {{CHUNK{1'b0}}, y_q[WIDTH-1:CHUNK]};
   end else begin : g_single
      assign x_shift = slice_sum;
      assign y_shift = y_q;
   end

   assign slice_ovf = (x_msb == y_msb) && (sum_msb != x_msb);

   always_comb begin
      final_res = x_shift;
`ifdef SATURATE_EN
      if (slice_ovf) begin
         final_res = x_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
   end

   assign last_slice    = (cnt_q == CW'(N - 1));
   assign bus.in_ready  = (state_q == ST_IDLE) && !rst;
   assign bus.out_valid = (state_q == ST_DONE);
   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.result    = result_q;
   assign bus.carry     = carry_q;
   assign bus.overflow  = overflow_q;

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      cnt_d      = cnt_q;
      x_d        = x_q;
      y_d        = y_q;
      cin_d      = cin_q;
      acc_d      = acc_q;
      result_d   = result_q;
      carry_d    = carry_q;
      overflow_d = overflow_q;

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               mode_d = bus.mode;
               cnt_d  = '0;
               cin_d  = (bus.mode == MODE_SUB);
               x_d    = (bus.mode == MODE_ACC) ? acc_q : bus.op_a;
               unique case (bus.mode)
                  MODE_SUB: y_d = ~bus.op_b;
                  MODE_ACC: y_d = bus.op_a;
                  default:  y_d = bus.op_b;
               endcase
               if (bus.mode == MODE_CLR) begin
                  acc_d      = '0;
                  result_d   = '0;
                  carry_d    = 1'b0;
                  overflow_d = 1'b0;
                  state_d    = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            x_d   = x_shift;
            y_d   = y_shift;
            cin_d = slice_cout;
            cnt_d = last_slice ? '0 : cnt_q + CW'(1);
            if (last_slice) begin
               result_d   = final_res;
               carry_d    = slice_cout;
               overflow_d = slice_ovf;
               if (mode_q == MODE_ACC) acc_d = final_res;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         result_q   <= '0;
         carry_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         result_q   <= result_d;
         carry_q    <= carry_d;
         overflow_q <= overflow_d;
      end
   end

   // NOTE: operand and slice-carry registers are always loaded at accept before use, so they need no reset.
   always_ff @(posedge clk) begin
      x_q    <= x_d;
      y_q    <= y_d;
      cin_q  <= cin_d;
      mode_q <= mode_d;
   end

endmodule

// File: doc/chunked_adder.md
# chunked_adder

Parametrised multi-cycle adder/accumulator: the next generation of the team's 8-bit combinational adder, generalised to WIDTH bits. It computes in CHUNK-bit slices over WIDTH/CHUNK cycles, carrying between slices, to trade latency for area. It adds subtract and accumulate modes, carry/overflow flags and valid/ready handshakes on both sides. It sits between an operand source and a result consumer inside the user project.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of CHUNK.
- CHUNK, 4, slice width processed per cycle; N = WIDTH/CHUNK slice cycles.
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept a request; high only in IDLE.
- op_a  input  WIDTH  operand A.
- op_b  input  WIDTH  operand B; ignored in ACC and CLR modes.
- mode  input  2  00 ADD, 01 SUB, 10 ACC, 11 CLR.
- out_valid  output  1  result, carry and overflow valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  sum or difference.
- carry  output  1  carry out of the MSB. For SUB, 1 means no borrow.
- overflow  output  1  two's-complement signed overflow.

## Operation
- The FSM has three states.
  - IDLE: in_ready=1. On in_valid&&in_ready, capture op_a, op_b (or the accumulator for ACC) and mode, then go to RUN (CLR goes to DONE).
  - RUN: one slice per cycle, LSB slice first. The slice carry is held in a flop. After slice N-1, go to DONE.
  - DONE: out_valid=1. Go to IDLE on out_valid&&out_ready.
- Mode arithmetic:
  - ADD: result = A + B, carry-in 0.
  - SUB: result = A + ~B, carry-in 1.
  - ACC: result = acc + A, and acc is loaded with result at the DONE entry.
  - CLR: acc = 0, result = 0, carry = 0, overflow = 0.
- Flag definitions:
  - overflow = (sign of X == sign of Y) && (sign of result != sign of X), where X and Y are the effective operands (~B for SUB).
  - carry is the final carry out of slice N-1.
- Inputs are sampled only at the accept cycle. Later changes on op_a, op_b and mode are ignored.
- result, carry and overflow stay stable from DONE entry until the output transfer. They keep their values in IDLE until the next DONE.
- acc is internal state, WIDTH bits, and persists across transactions.
- Reset:
  - Values: state=IDLE, acc=0, result=0, carry=0, overflow=0, out_valid=0, in_ready=0 during the reset cycle, in_ready=1 on the first cycle after.
  - Reset in RUN or DONE discards the transaction with no output, and acc is not updated.

## Timing
- Request accepted at edge T. Slices are processed in cycles T+1..T+N. out_valid rises at T+N+1.
- CLR: out_valid rises at T+1.
- Minimum period between accepts is N+2 cycles with out_ready held high: the output transfer at T+N+1 returns to IDLE, and the next accept is at T+N+2.
- in_ready and out_valid are never high together.
- out_ready low in DONE holds indefinitely with outputs stable.
- out_ready is ignored outside DONE.

## Configuration
- SATURATE_EN defined:
  - On signed overflow, result is clamped to 0x7FF…F for positive overflow or 0x800…0 for negative overflow, and overflow=1.
  - In ACC mode, acc stores the clamped value.
  - carry is unaffected.
- SATURATE_EN undefined: result wraps modulo 2^WIDTH, and overflow is reported only.

## Structure
- Package adder_pkg holds:
  - a mode enum (MODE_ADD, MODE_SUB, MODE_ACC, MODE_CLR);
  - a state enum (ST_IDLE, ST_RUN, ST_DONE).
- Sub-module chunk_add: CHUNK-bit combinational slice adder. Inputs a, b, cin. Outputs sum, cout, and the slice MSB signs needed for overflow.
- The top level owns the FSM, the slice counter ($clog2(N) bits, wraps to 0 at DONE entry), the operand shift registers, acc and the output registers.

## Test plan
All scenarios use WIDTH=16, CHUNK=4.
- Basic add: reset, then ADD 0x00FF + 0x0001 -> result 0x0100, carry 0, overflow 0. out_valid exactly 5 cycles after accept. in_ready low throughout.
- Signed overflow: ADD 0x7FFF + 0x0001 -> 0x8000, overflow 1, carry 0. With SATURATE_EN: 0x7FFF, overflow 1. Also ADD 0xFFFF + 0x0001 -> 0x0000, carry 1, overflow 0.
- Subtract: SUB 0x0005 − 0x0007 -> 0xFFFE, carry 0. SUB 0x0007 − 0x0005 -> 0x0002, carry 1.
- Accumulate: CLR -> result 0, out_valid 1 cycle after accept. Then ACC 0x1000 three times -> results 0x1000, 0x2000, 0x3000. Change op_a to 0xAAAA the cycle after each accept; the results must be unaffected.
- Backpressure: hold out_ready low for 10 cycles in DONE -> out_valid and result stay stable and in_ready stays 0. Raise out_ready, and the next accept is possible one cycle later.
- Reset mid-run: accept ACC 0x0010 with acc=0x0100, assert rst in the second RUN cycle -> no out_valid, acc reads 0. The next ACC 0x0001 yields 0x0001.
